// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: key sync/debounce/edge-detect, RUN/PAUSE/LAP FSM, 1 Hz timebase.
// Latency: key low -> state/running change after 2 + DEBOUNCE + 1 cycles; all outputs registered.
// Backpressure: none; pulses are fire-and-forget to the BCD counter datapath.

module stopwatch_key_filter #(
    parameter int DEBOUNCE = 1000000
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            meta_q <= key_n;
            sync_q <= meta_q;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Fires in the cycle the low level is accepted, so the FSM acts on the same edge level_q falls.
    assign press = level_q & ~sync_q & (cnt_q == CNT_MAX);
endmodule

module stopwatch_ctrl #(
    parameter int CLK_HZ   = 50000000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       key_start_n,
    input  logic       key_stop_n,
    input  logic       key_clr_n,
    input  logic       key_lap_n,
    output logic       tick,
    output logic       clr,
    output logic       running,
    output logic       lap_hold,
    output logic [1:0] state
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            tick_d;

    logic press_start, press_stop, press_clr, press_lap;
    logic evt_start, evt_stop, evt_clr, evt_lap;
    logic active, active_next;

    stopwatch_key_filter #(.DEBOUNCE(DEBOUNCE)) u_key_start (
        .Clk(Clk), .reset_n(reset_n), .key_n(key_start_n), .press(press_start));
    stopwatch_key_filter #(.DEBOUNCE(DEBOUNCE)) u_key_stop (
        .Clk(Clk), .reset_n(reset_n), .key_n(key_stop_n), .press(press_stop));
    stopwatch_key_filter #(.DEBOUNCE(DEBOUNCE)) u_key_clr (
        .Clk(Clk), .reset_n(reset_n), .key_n(key_clr_n), .press(press_clr));
    stopwatch_key_filter #(.DEBOUNCE(DEBOUNCE)) u_key_lap (
        .Clk(Clk), .reset_n(reset_n), .key_n(key_lap_n), .press(press_lap));

    // Only the highest-priority coincident event survives: clr > stop > start > lap.
    always_comb begin
        evt_clr   = press_clr;
        evt_stop  = press_stop  & ~press_clr;
        evt_start = press_start & ~press_clr & ~press_stop;
        evt_lap   = press_lap   & ~press_clr & ~press_stop & ~press_start;
    end

    always_comb begin
        state_d = state_q;
        if (evt_clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (evt_start) state_d = RUN;
                RUN:     if (evt_stop)  state_d = PAUSE;
                         else if (evt_lap) state_d = LAP;
                PAUSE:   if (evt_start) state_d = RUN;
                LAP:     if (evt_stop)  state_d = PAUSE;
                         else if (evt_lap) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign active      = (state_q == RUN) || (state_q == LAP);
    assign active_next = (state_d == RUN) || (state_d == LAP);

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (evt_clr || (state_q == IDLE)) begin
            presc_d = '0;
        end else if (active) begin
            if (presc_q == PRESC_MAX) begin
                // A wrap on the pause edge is held back so the tick lands inside RUN/LAP on resume.
                if (active_next) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tick     <= 1'b0;
            clr      <= 1'b0;
            running  <= 1'b0;
            lap_hold <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick     <= tick_d;
            clr      <= evt_clr;
            running  <= active_next;
            lap_hold <= (state_d == LAP);
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_HZ=10, DEBOUNCE=4: directed key sequences, expected output events queued ahead of time.
// Latency: n/a. Backpressure: n/a.
module tb_stopwatch_ctrl;
    localparam int K_TICK = 0;
    localparam int K_CLR  = 1;
    localparam int K_ST   = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [1:0] st;
        logic       run;
        logic       lh;
    } exp_t;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic       key_start_n, key_stop_n, key_clr_n, key_lap_n;
    logic       tick, clr, running, lap_hold;
    logic [1:0] state;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic [3:0] prev_obs = 4'b0000;
    exp_t expq[$];

    int a, r1, p, q, e0, r2, b, f0, r3;

    stopwatch_ctrl #(.CLK_HZ(10), .DEBOUNCE(4)) dut (
        .Clk(Clk), .reset_n(reset_n),
        .key_start_n(key_start_n), .key_stop_n(key_stop_n),
        .key_clr_n(key_clr_n), .key_lap_n(key_lap_n),
        .tick(tick), .clr(clr), .running(running),
        .lap_hold(lap_hold), .state(state));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_TICK:  return "tick";
            K_CLR:   return "clr";
            default: return "state";
        endcase
    endfunction

    task automatic push(input int c, input int k, input logic [1:0] st, input logic run, input logic lh);
        exp_t e;
        e.cyc = c; e.kind = k; e.st = st; e.run = run; e.lh = lh;
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input int k);
        exp_t e;
        tests++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected %s at cyc %0d: got st=%0d run=%0b lap=%0b, expected no event",
                     kname(k), cyc, state, running, lap_hold);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.cyc != cyc || e.st != state || e.run != running || e.lh != lap_hold) begin
                fails++;
                $display("FAIL %s event: got %s cyc=%0d st=%0d run=%0b lap=%0b, expected %s cyc=%0d st=%0d run=%0b lap=%0b",
                         kname(e.kind), kname(k), cyc, state, running, lap_hold,
                         kname(e.kind), e.cyc, e.st, e.run, e.lh);
            end
        end
    endtask

    // Monitor: every output event is popped against the scoreboard in clr, state, tick order.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (clr) observe(K_CLR);
            if ({state, running, lap_hold} != prev_obs) observe(K_ST);
            if (tick) observe(K_TICK);
        end
        prev_obs = {state, running, lap_hold};
    end

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    initial begin
        reset_n = 1'b1;
        key_start_n = 1'b1; key_stop_n = 1'b1; key_clr_n = 1'b1; key_lap_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset tick", int'(tick), 0);
        chk("reset clr", int'(clr), 0);
        chk("reset running", int'(running), 0);
        chk("reset lap_hold", int'(lap_hold), 0);
        chk("reset state", int'(state), 0);
        #2 reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge Clk);

        // Start from reset
        a = cyc; r1 = a + 7;
        push(r1, K_ST, 2'b01, 1, 0);
        push(r1 + 10, K_TICK, 2'b01, 1, 0);
        push(r1 + 20, K_TICK, 2'b01, 1, 0);
        push(r1 + 30, K_TICK, 2'b01, 1, 0);
        key_start_n = 1'b0;
        at_cyc(a + 20); key_start_n = 1'b1;

        // Pause 4 cycles after a tick, hold 50, resume: 6 active cycles left
        at_cyc(r1 + 27);
        p = r1 + 34;
        push(p, K_ST, 2'b10, 0, 0);
        key_stop_n = 1'b0;
        at_cyc(r1 + 37); key_stop_n = 1'b1;
        q = p + 50;
        at_cyc(q - 7);
        push(q, K_ST, 2'b01, 1, 0);
        push(q + 6, K_TICK, 2'b01, 1, 0);
        key_start_n = 1'b0;

        // Lap in and out
        at_cyc(q + 2);
        push(q + 9, K_ST, 2'b11, 1, 1);
        push(q + 16, K_TICK, 2'b11, 1, 1);
        push(q + 26, K_TICK, 2'b11, 1, 1);
        key_lap_n = 1'b0;
        at_cyc(q + 3); key_start_n = 1'b1;
        at_cyc(q + 12); key_lap_n = 1'b1;
        at_cyc(q + 23);
        push(q + 30, K_ST, 2'b01, 1, 0);
        push(q + 36, K_TICK, 2'b01, 1, 0);
        push(q + 46, K_TICK, 2'b01, 1, 0);
        key_lap_n = 1'b0;
        at_cyc(q + 33); key_lap_n = 1'b1;

        // Clear and start together, landing on a would-be tick cycle
        at_cyc(q + 49);
        push(q + 56, K_CLR, 2'b00, 0, 0);
        push(q + 56, K_ST, 2'b00, 0, 0);
        key_clr_n = 1'b0; key_start_n = 1'b0;
        at_cyc(q + 59); key_clr_n = 1'b1; key_start_n = 1'b1;

        // Restart, then bounce on stop, then a clean stop
        at_cyc(q + 70);
        e0 = cyc; r2 = e0 + 7;
        push(r2, K_ST, 2'b01, 1, 0);
        push(r2 + 10, K_TICK, 2'b01, 1, 0);
        push(r2 + 20, K_TICK, 2'b01, 1, 0);
        push(r2 + 30, K_TICK, 2'b01, 1, 0);
        key_start_n = 1'b0;
        at_cyc(e0 + 10); key_start_n = 1'b1;
        b = r2 + 12;
        at_cyc(b);     key_stop_n = 1'b0;
        at_cyc(b + 3); key_stop_n = 1'b1;
        at_cyc(b + 5); key_stop_n = 1'b0;
        at_cyc(b + 8); key_stop_n = 1'b1;
        at_cyc(b + 12);
        push(r2 + 31, K_ST, 2'b10, 0, 0);
        key_stop_n = 1'b0;
        at_cyc(b + 20); key_stop_n = 1'b1;

        // Resume (prescaler held at 1), enter LAP, async reset 5 cycles after a tick
        at_cyc(r2 + 40);
        f0 = cyc; r3 = f0 + 7;
        push(r3, K_ST, 2'b01, 1, 0);
        push(r3 + 9, K_TICK, 2'b01, 1, 0);
        key_start_n = 1'b0;
        at_cyc(f0 + 10); key_start_n = 1'b1;
        at_cyc(r3 + 5);
        push(r3 + 12, K_ST, 2'b11, 1, 1);
        push(r3 + 19, K_TICK, 2'b11, 1, 1);
        key_lap_n = 1'b0;
        at_cyc(r3 + 15); key_lap_n = 1'b1;
        at_cyc(r3 + 24);
        push(r3 + 25, K_ST, 2'b00, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset tick", int'(tick), 0);
        chk("async reset clr", int'(clr), 0);
        chk("async reset running", int'(running), 0);
        chk("async reset lap_hold", int'(lap_hold), 0);
        chk("async reset state", int'(state), 0);
        at_cyc(r3 + 28);
        #2 reset_n = 1'b1;
        at_cyc(r3 + 80);

        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            tests++;
            fails++;
            $display("FAIL missing %s: got no event, expected cyc=%0d st=%0d", kname(e.kind), e.cyc, e.st);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
